// File: rtl/wb_queue.sv
// Write-back queue: buffers completed results and drains one per cycle into the register file and flag register.
// Latency: an entry pushed at edge t is driven in cycle t+1 and committed at edge t+1; bypass reads current state combinationally.
// Backpressure: push_ready = !full; the producer holds its entry while push_ready is low.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [3:0]                 push_reg,
    input  logic [15:0]                push_data,
    input  logic [2:0]                 push_flag_wen,
    input  logic [2:0]                 push_flags,
    output logic [3:0]                 DstReg,
    output logic [15:0]                DstData,
    output logic                       WriteReg,
    output logic                       n_write,
    output logic                       v_write,
    output logic                       z_write,
    output logic                       n_in,
    output logic                       v_in,
    output logic                       z_in,
    input  logic [3:0]                 src1_reg,
    input  logic [3:0]                 src2_reg,
    output logic                       src1_hit,
    output logic                       src2_hit,
    output logic [15:0]                src1_data,
    output logic [15:0]                src2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  rg;
        logic [15:0] dat;
        logic [2:0]  wen;   // {n,v,z}
        logic [2:0]  flg;   // {n,v,z}
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_e;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == (AW+1)'(DEPTH));
    assign push_ready = !full;
    assign count      = count_q;
    assign do_push    = push_valid && push_ready;
    // The register file captures the head on every edge the queue is non-empty.
    assign do_pop     = !empty;

    // Pointer and occupancy tracking; reset drops every pending entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because validity comes from count.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[tail] <= '{rg: push_reg, dat: push_data, wen: push_flag_wen, flg: push_flags};
        end
    end

    assign head_e = mem[head];

    // Head entry onto the register-file and flag write ports, zeroed when empty.
    always_comb begin
        DstReg   = '0;
        DstData  = '0;
        WriteReg = 1'b0;
        n_write  = 1'b0;
        v_write  = 1'b0;
        z_write  = 1'b0;
        n_in     = 1'b0;
        v_in     = 1'b0;
        z_in     = 1'b0;
        if (!empty) begin
            DstReg   = head_e.rg;
            DstData  = head_e.dat;
            WriteReg = (head_e.rg != 4'd0);
            {n_write, v_write, z_write} = head_e.wen;
            {n_in, v_in, z_in}          = head_e.flg;
        end
    end

    // Bypass: walk from oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx       = '0;
        src1_hit  = 1'b0;
        src2_hit  = 1'b0;
        src1_data = '0;
        src2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((AW+1)'(i) < count_q) begin
                if (src1_reg != 4'd0 && mem[idx].rg == src1_reg) begin
                    src1_hit  = 1'b1;
                    src1_data = mem[idx].dat;
                end
                if (src2_reg != 4'd0 && mem[idx].rg == src2_reg) begin
                    src2_hit  = 1'b1;
                    src2_data = mem[idx].dat;
                end
            end
        end
    end
endmodule
